// File: rtl/mem_access_ctl.sv
// CPU-to-memory access controller: decodes CPU cycles onto SDRAM (ROM/RAM) or on-chip devices.
// Optional SDRAM ack watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctl #(
    parameter int              ADDR_W   = 20,
    parameter int              SDR_W    = 25,
    parameter logic [SDR_W-1:0] ROM_BASE = 25'h000_0000,
    parameter logic [SDR_W-1:0] RAM_BASE = 25'h010_0000,
    parameter int              DEV_LAT  = 2,
    parameter int              TIMEOUT  = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [1:0]        memory_map,
    input  logic [3:0]        rom_bank,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_be,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              sdr_req,
    output logic              sdr_we,
    output logic [SDR_W-1:0]  sdr_addr,
    output logic [1:0]        sdr_be,
    output logic [15:0]       sdr_wdata,
    input  logic [15:0]       sdr_rdata,
    input  logic              sdr_ack,
    output logic [4:0]        dev_sel,
    input  logic [15:0]       dev_rdata,
    output logic              bus_err
);

    typedef enum logic [2:0] {IDLE, DECODE, SDR_WAIT, DEV_WAIT, DONE} state_t;

    // Device windows, indexed by dev_sel bit
    localparam logic [19:0] DEV_LO [5] = '{20'hF8000, 20'hF8800, 20'hF9000, 20'hF9800, 20'hD0000};
    localparam logic [19:0] DEV_HI [5] = '{20'hF87FF, 20'hF8FFF, 20'hF900F, 20'hF9801, 20'hDFFFF};

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic               we_reg;
    logic [1:0]         be_reg;
    logic [15:0]        wdata_reg;
    logic [1:0]         map_reg;
    logic [3:0]         bank_reg;
    logic [15:0]        rdata_reg;
    logic [3:0]         dev_cnt_reg;
    logic               cpu_ready_reg;
    logic [15:0]        cpu_rdata_reg;
    logic               sdr_req_reg, sdr_we_reg;
    logic [SDR_W-1:0]   sdr_addr_reg;
    logic [1:0]         sdr_be_reg;
    logic [15:0]        sdr_wdata_reg;
    logic [4:0]         dev_sel_reg;

    logic [19:0]        addr20;
    logic [4:0]         dev_hit;
    logic               rom_hit, ram_hit, dec_sdr;
    logic [4:0]         dec_dev;
    logic [SDR_W-1:0]   dec_addr;
    logic               accept, dev_last, timeout_hit;

    assign addr20   = 20'(addr_reg);
    // The request is still held during the cpu_ready cycle; it must not restart a cycle
    assign accept   = (state_reg == IDLE) && cpu_req && !cpu_ready_reg;
    assign dev_last = (dev_cnt_reg == 4'(DEV_LAT - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dev_hit
            assign dev_hit[gi] = (addr20 >= DEV_LO[gi]) && (addr20 <= DEV_HI[gi]);
        end
    endgenerate

    always_comb begin
        rom_hit  = 1'b0;
        ram_hit  = 1'b0;
        dec_dev  = '0;
        dec_addr = '0;
        if (map_reg == 2'd1 && addr20[19:17] == 3'b101) begin
            rom_hit  = 1'b1;
            dec_addr = ROM_BASE | SDR_W'({bank_reg, addr20[16:0]});
        end else if (!map_reg[1]) begin
            if (|dev_hit) begin
                dec_dev = dev_hit;
            end else if (addr20[19:16] == 4'hC) begin
                rom_hit  = 1'b1;
                dec_addr = ROM_BASE | SDR_W'(addr20[15:0]);
            end else if (addr20[19:16] == 4'hE) begin
                ram_hit  = 1'b1;
                dec_addr = RAM_BASE | SDR_W'(addr20[15:0]);
            end else if (addr20[19:4] == 16'hFFFF) begin
                rom_hit  = 1'b1;
                dec_addr = ROM_BASE | SDR_W'({16'h7FFF, addr20[3:0]});
            end else begin
                rom_hit  = 1'b1;
                dec_addr = ROM_BASE | SDR_W'(addr_reg);
            end
        end
        dec_sdr = ram_hit | (rom_hit & ~we_reg);
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [15:0] wd_cnt_reg;
    logic        bus_err_reg;

    assign timeout_hit = (state_reg == SDR_WAIT) && !sdr_ack && (wd_cnt_reg == 16'(TIMEOUT - 1));
    assign bus_err     = bus_err_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wd_cnt_reg  <= '0;
            bus_err_reg <= 1'b0;
        end else if (state_reg == DECODE) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == SDR_WAIT) begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
            if (timeout_hit) bus_err_reg <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept) state_next = DECODE;
            DECODE: begin
                if (dec_sdr)       state_next = SDR_WAIT;
                else if (|dec_dev) state_next = DEV_WAIT;
                else               state_next = DONE;
            end
            SDR_WAIT: if (sdr_ack || timeout_hit) state_next = DONE;
            DEV_WAIT: if (dev_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            map_reg       <= '0;
            bank_reg      <= '0;
            rdata_reg     <= '0;
            dev_cnt_reg   <= '0;
            cpu_ready_reg <= 1'b0;
            cpu_rdata_reg <= '0;
            sdr_req_reg   <= 1'b0;
            sdr_we_reg    <= 1'b0;
            sdr_addr_reg  <= '0;
            sdr_be_reg    <= '0;
            sdr_wdata_reg <= '0;
            dev_sel_reg   <= '0;
        end else begin
            cpu_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: if (accept) begin
                    addr_reg  <= cpu_addr;
                    we_reg    <= cpu_we;
                    be_reg    <= cpu_be;
                    wdata_reg <= cpu_wdata;
                    map_reg   <= memory_map;
                    bank_reg  <= rom_bank;
                end
                DECODE: begin
                    if (dec_sdr) begin
                        sdr_req_reg   <= 1'b1;
                        sdr_we_reg    <= we_reg;
                        sdr_addr_reg  <= dec_addr;
                        sdr_be_reg    <= be_reg;
                        sdr_wdata_reg <= wdata_reg;
                    end else if (|dec_dev) begin
                        dev_sel_reg <= dec_dev;
                        dev_cnt_reg <= '0;
                    end else begin
                        rdata_reg <= 16'hFFFF;
                    end
                end
                SDR_WAIT: begin
                    if (sdr_ack) begin
                        rdata_reg   <= sdr_rdata;
                        sdr_req_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_reg   <= 16'hFFFF;
                        sdr_req_reg <= 1'b0;
                    end
                end
                DEV_WAIT: begin
                    if (dev_last) begin
                        rdata_reg   <= dev_rdata;
                        dev_sel_reg <= '0;
                    end else begin
                        dev_cnt_reg <= dev_cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    cpu_ready_reg <= 1'b1;
                    cpu_rdata_reg <= rdata_reg;
                end
                default: ;
            endcase
        end
    end

    assign cpu_ready = cpu_ready_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign sdr_req   = sdr_req_reg;
    assign sdr_we    = sdr_we_reg;
    assign sdr_addr  = sdr_addr_reg;
    assign sdr_be    = sdr_be_reg;
    assign sdr_wdata = sdr_wdata_reg;
    assign dev_sel   = dev_sel_reg;

endmodule

// File: tb/tb_mem_access_ctl.sv
// Randomized self-checking bench for mem_access_ctl against a timeline model of each access.
// Builds with or without MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_ctl;
    localparam int DEV_LAT = 2;
    localparam int TIMEOUT = 20;
    localparam logic [24:0] ROM_BASE = 25'h000_0000;
    localparam logic [24:0] RAM_BASE = 25'h010_0000;
    localparam int K_NONE = 0, K_SDR = 1, K_DEV = 2;

    logic        clk_sys = 0, reset = 1;
    logic [1:0]  memory_map = 0;
    logic [3:0]  rom_bank = 0;
    logic        cpu_req = 0, cpu_we = 0;
    logic [19:0] cpu_addr = 0;
    logic [1:0]  cpu_be = 0;
    logic [15:0] cpu_wdata = 0, cpu_rdata;
    logic        cpu_ready, sdr_req, sdr_we, sdr_ack = 0, bus_err;
    logic [24:0] sdr_addr;
    logic [1:0]  sdr_be;
    logic [15:0] sdr_wdata, sdr_rdata = 0, dev_rdata = 0;
    logic [4:0]  dev_sel;

    mem_access_ctl #(.ADDR_W(20), .SDR_W(25), .ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE),
                     .DEV_LAT(DEV_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset), .memory_map(memory_map), .rom_bank(rom_bank),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .sdr_req(sdr_req), .sdr_we(sdr_we), .sdr_addr(sdr_addr), .sdr_be(sdr_be),
        .sdr_wdata(sdr_wdata), .sdr_rdata(sdr_rdata), .sdr_ack(sdr_ack),
        .dev_sel(dev_sel), .dev_rdata(dev_rdata), .bus_err(bus_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    // Current transaction as seen by the model
    bit          t_active = 0, t_we = 0, t_noack = 0;
    int          t_c0 = 0, t_kind = 0, t_dev = -1, t_lat = 0, t_w = 1;
    logic [24:0] t_saddr = 0;
    logic [1:0]  t_be = 0;
    logic [15:0] t_wdata = 0, t_sdr_data = 0;
    int          berr_cyc = -1;
    int          ready_base = 0;

    // Observations (written only by the responder / monitor)
    logic [15:0] dev_last_data = 0, last_rdata = 0;
    logic [24:0] seen_sdr_addr = 0;
    logic [4:0]  seen_dev_sel = 0;
    int          ready_count = 0, ready_rel = -1, ack_n = 0;

    logic [19:0] corners [24] = '{20'hA0000, 20'hBFFFF, 20'h9FFFF, 20'hC0000, 20'hCFFFF, 20'hD0000,
                                  20'hDFFFF, 20'hE0000, 20'hEFFFF, 20'hF0000, 20'hF7FFF, 20'hF8000,
                                  20'hF87FF, 20'hF8800, 20'hF8FFF, 20'hF9000, 20'hF900F, 20'hF9010,
                                  20'hF9800, 20'hF9801, 20'hF9802, 20'hFFFEF, 20'hFFFF0, 20'hFFFFF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Address map as a plain table of ranges
    function automatic void model_decode(input logic [1:0] map, input logic [3:0] bank,
                                         input logic we, input logic [19:0] a,
                                         output int kind, output logic [24:0] sa, output int dev);
        int unsigned u;
        bit rom, ram;
        u = a; rom = 0; ram = 0; sa = '0; dev = -1; kind = K_NONE;
        if (map >= 2) return;
        if (map == 1 && u >= 'hA0000 && u < 'hC0000) begin
            rom = 1; sa = ROM_BASE | 25'(bank * 'h20000 + u % 'h20000);
        end else if (u >= 'hC0000 && u < 'hD0000) begin
            rom = 1; sa = ROM_BASE | 25'(u % 'h10000);
        end else if (u >= 'hD0000 && u < 'hE0000) dev = 4;
        else if (u >= 'hE0000 && u < 'hF0000) begin
            ram = 1; sa = RAM_BASE | 25'(u % 'h10000);
        end else if (u >= 'hF8000 && u < 'hF8800) dev = 0;
        else if (u >= 'hF8800 && u < 'hF9000) dev = 1;
        else if (u >= 'hF9000 && u < 'hF9010) dev = 2;
        else if (u >= 'hF9800 && u < 'hF9802) dev = 3;
        else if (u >= 'hFFFF0) begin
            rom = 1; sa = ROM_BASE | 25'('h7FFF0 + u % 16);
        end else begin
            rom = 1; sa = ROM_BASE | 25'(u);
        end
        if (dev >= 0)            kind = K_DEV;
        else if (ram || !we)     kind = K_SDR;
        else                     kind = K_NONE;
    endfunction

    // SDRAM and device responders
    always @(negedge clk_sys) begin
        sdr_ack   = 0;
        sdr_rdata = 16'($urandom);
        dev_rdata = 16'($urandom);
        if (sdr_req) begin
            ack_n++;
            if (!t_noack && ack_n == t_w) begin
                sdr_ack   = 1;
                sdr_rdata = t_sdr_data;
            end
        end else begin
            ack_n = 0;
            if ($urandom_range(0, 3) == 0) sdr_ack = 1;
        end
        if (t_active && t_kind == K_DEV && cyc - t_c0 == 1 + DEV_LAT) dev_last_data = dev_rdata;
    end

    // Per-cycle compare against the transaction timeline
    always @(negedge clk_sys) begin
        int rel;
        logic exp_req, exp_rdy, exp_berr;
        logic [4:0] exp_sel;
        logic [15:0] exp_rd;
        if (!reset) begin
            rel = t_active ? (cyc - t_c0) : -100;
            if (rel == 1) begin
                seen_sdr_addr = '0;
                seen_dev_sel  = '0;
            end
`ifdef MEM_ACCESS_TIMEOUT_EN
            exp_req = t_active && t_kind == K_SDR && rel >= 2 &&
                      (t_noack ? (rel <= 1 + TIMEOUT) : (rel <= 1 + t_w));
`else
            exp_req = t_active && t_kind == K_SDR && rel >= 2 && (t_noack || rel <= 1 + t_w);
`endif
            exp_sel  = (t_active && t_kind == K_DEV && rel >= 2 && rel <= 1 + DEV_LAT) ? 5'(1 << t_dev) : 5'd0;
            exp_rdy  = t_active && rel == t_lat;
            exp_berr = (berr_cyc >= 0) && (cyc >= berr_cyc);
            chk("cpu_ready", 32'(cpu_ready), 32'(exp_rdy));
            chk("sdr_req", 32'(sdr_req), 32'(exp_req));
            chk("dev_sel", 32'(dev_sel), 32'(exp_sel));
            chk("bus_err", 32'(bus_err), 32'(exp_berr));
            if (exp_req && sdr_req) begin
                chk("sdr_addr", 32'(sdr_addr), 32'(t_saddr));
                chk("sdr_we", 32'(sdr_we), 32'(t_we));
                chk("sdr_be", 32'(sdr_be), 32'(t_be));
                chk("sdr_wdata", 32'(sdr_wdata), 32'(t_wdata));
                seen_sdr_addr = sdr_addr;
            end
            if (dev_sel != 0) seen_dev_sel = dev_sel;
            if (exp_rdy && cpu_ready) begin
                if (t_kind == K_DEV)                 exp_rd = dev_last_data;
                else if (t_kind == K_SDR && !t_noack) exp_rd = t_sdr_data;
                else                                 exp_rd = 16'hFFFF;
                if (!t_we) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
                last_rdata = cpu_rdata;
                ready_rel  = rel;
            end
            if (cpu_ready) ready_count++;
        end
    end

    task automatic do_reset();
        @(posedge clk_sys); #2;
        reset = 1; cpu_req = 0; t_active = 0; berr_cyc = -1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_cpu_ready", 32'(cpu_ready), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_sdr_req", 32'(sdr_req), 0);
        chk("rst_sdr_we", 32'(sdr_we), 0);
        chk("rst_sdr_addr", 32'(sdr_addr), 0);
        chk("rst_sdr_be", 32'(sdr_be), 0);
        chk("rst_sdr_wdata", 32'(sdr_wdata), 0);
        chk("rst_dev_sel", 32'(dev_sel), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        reset = 0;
    endtask

    task automatic start_txn(input logic [1:0] map, input logic [3:0] bank, input logic we,
                             input logic [19:0] addr, input int w, input bit noack);
        int kind, dev;
        logic [24:0] sa;
        model_decode(map, bank, we, addr, kind, sa, dev);
        @(negedge clk_sys);
        t_kind = kind; t_dev = dev; t_saddr = sa; t_we = we; t_w = w; t_noack = noack;
        t_be = 2'($urandom); t_wdata = 16'($urandom); t_sdr_data = 16'($urandom);
        if (kind == K_NONE)      t_lat = 3;
        else if (kind == K_DEV)  t_lat = 3 + DEV_LAT;
        else if (!noack)         t_lat = 3 + w;
        else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
            t_lat = 3 + TIMEOUT;
            berr_cyc = cyc + 2 + TIMEOUT;
`else
            t_lat = -1;
`endif
        end
        t_c0 = cyc; ready_base = ready_count; t_active = 1;
        memory_map = map; rom_bank = bank; cpu_we = we; cpu_addr = addr;
        cpu_be = t_be; cpu_wdata = t_wdata; cpu_req = 1;
    endtask

    task automatic finish_txn();
        int n = 0;
        while (ready_count == ready_base && n < 300) begin
            @(posedge clk_sys); #2;
            n++;
        end
        checks++;
        if (ready_count == ready_base) begin
            errors++;
            $display("FAIL txn_timeout: got no cpu_ready, expected one within 300 cycles (cycle %0d)", cyc);
        end
        cpu_req = 0; t_active = 0;
        $display("txn map=%0d bank=%0h we=%0d addr=%05h kind=%0d lat=%0d rdata=%04h",
                 memory_map, rom_bank, cpu_we, cpu_addr, t_kind, ready_rel, last_rdata);
        if (ready_count == ready_base) do_reset();
        repeat ($urandom_range(1, 3)) @(posedge clk_sys);
    endtask

    task automatic run_txn(input logic [1:0] map, input logic [3:0] bank, input logic we,
                           input logic [19:0] addr, input int w);
        start_txn(map, bank, we, addr, w, 0);
        finish_txn();
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        do_reset();

        run_txn(2'd0, 4'h0, 1'b0, 20'hE1234, 3);
        chk("ram_read_addr", 32'(seen_sdr_addr), 32'h0101234);
        chk("ram_read_latency", 32'(ready_rel), 32'd6);
        chk("ram_read_data", 32'(last_rdata), 32'(t_sdr_data));
        run_txn(2'd0, 4'h0, 1'b0, 20'hFFFF4, 1);
        chk("vector_rom_addr", 32'(seen_sdr_addr), 32'h007FFF4);
        chk("vector_rom_latency", 32'(ready_rel), 32'd4);
        run_txn(2'd0, 4'h0, 1'b1, 20'hC0000, 1);
        chk("rom_write_latency", 32'(ready_rel), 32'd3);
        chk("rom_write_no_sdr", 32'(seen_sdr_addr), 32'h0);
        run_txn(2'd1, 4'h3, 1'b0, 20'hA0010, 2);
        chk("bank_window_addr", 32'(seen_sdr_addr), 32'h0060010);
        run_txn(2'd0, 4'h3, 1'b0, 20'hA0010, 2);
        chk("map0_a0010_addr", 32'(seen_sdr_addr), 32'h00A0010);
        run_txn(2'd0, 4'h0, 1'b1, 20'hF8802, 1);
        chk("palette_sel", 32'(seen_dev_sel), 32'b00010);
        chk("palette_latency", 32'(ready_rel), 32'd5);
        run_txn(2'd2, 4'h0, 1'b0, 20'hE0000, 1);
        chk("unmapped_rdata", 32'(last_rdata), 32'hFFFF);
        chk("unmapped_latency", 32'(ready_rel), 32'd3);

`ifdef MEM_ACCESS_TIMEOUT_EN
        start_txn(2'd0, 4'h0, 1'b0, 20'hE0100, 1, 1);
        finish_txn();
        chk("timeout_rdata", 32'(last_rdata), 32'hFFFF);
        chk("timeout_latency", 32'(ready_rel), 32'(3 + TIMEOUT));
        chk("timeout_bus_err", 32'(bus_err), 32'd1);
        run_txn(2'd0, 4'h0, 1'b0, 20'hE0200, 2);
        chk("bus_err_sticky", 32'(bus_err), 32'd1);
        start_txn(2'd0, 4'h0, 1'b0, 20'hC0042, 1, 1);
        repeat (8) @(posedge clk_sys);
`else
        start_txn(2'd0, 4'h0, 1'b0, 20'hC0042, 1, 1);
        repeat (30) @(posedge clk_sys);
`endif
        #2;
        chk("noack_req_held", 32'(sdr_req), 32'd1);
        chk("noack_no_ready", 32'(ready_count - ready_base), 32'd0);
        do_reset();
        repeat (5) @(posedge clk_sys);
        chk("abort_no_ready", 32'(ready_count - ready_base), 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [1:0]  m;
            logic [19:0] a;
            m = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            a = ($urandom_range(0, 2) == 0) ? 20'($urandom) : corners[$urandom_range(0, 23)];
            run_txn(m, 4'($urandom), 1'($urandom), a, $urandom_range(1, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_watchdog: simulation did not complete, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
